// File: rtl/ps2_kb_pkg.sv
// Shared constants and state type for the ASCII-to-PS/2 keyboard sequencer.
// ASCII2KEY_SHIFT_EN widens the byte index so the 6-byte shifted sequence fits.
package ps2_kb_pkg;
    localparam logic [7:0] BREAK_CODE  = 8'hF0;
    localparam logic [7:0] LSHIFT_CODE = 8'h12;

    localparam int SEQ_LEN_BASE  = 3;
    localparam int SEQ_LEN_SHIFT = 6;

`ifdef ASCII2KEY_SHIFT_EN
    localparam int IDX_W = 3;
`else
    localparam int IDX_W = 2;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_DONE,
        GAP
    } state_t;
endpackage

// File: rtl/ascii2scan_lut.sv
// Combinational ASCII to PS/2 set-2 make-code lookup; lowercase letters fold to uppercase.
// With ASCII2KEY_SHIFT_EN defined, an extra needs_shift output flags uppercase 'A'-'Z'.
module ascii2scan_lut (
    input  logic [7:0] ascii_code,
    output logic       valid,
    output logic [7:0] make_code
`ifdef ASCII2KEY_SHIFT_EN
    ,
    output logic       needs_shift
`endif
);
    logic [7:0] folded;

    always_comb begin
        folded = ascii_code;
        if (ascii_code >= 8'h61 && ascii_code <= 8'h7A)
            folded = ascii_code - 8'h20;
    end

`ifdef ASCII2KEY_SHIFT_EN
    assign needs_shift = (ascii_code >= 8'h41) && (ascii_code <= 8'h5A);
`endif

    always_comb begin
        valid     = 1'b1;
        make_code = 8'h00;
        case (folded)
            8'h30: make_code = 8'h45;
            8'h31: make_code = 8'h16;
            8'h32: make_code = 8'h1E;
            8'h33: make_code = 8'h26;
            8'h34: make_code = 8'h25;
            8'h35: make_code = 8'h2E;
            8'h36: make_code = 8'h36;
            8'h37: make_code = 8'h3D;
            8'h38: make_code = 8'h3E;
            8'h39: make_code = 8'h46;
            8'h41: make_code = 8'h1C;
            8'h42: make_code = 8'h32;
            8'h43: make_code = 8'h21;
            8'h44: make_code = 8'h23;
            8'h45: make_code = 8'h24;
            8'h46: make_code = 8'h2B;
            8'h47: make_code = 8'h34;
            8'h48: make_code = 8'h33;
            8'h49: make_code = 8'h43;
            8'h4A: make_code = 8'h3B;
            8'h4B: make_code = 8'h42;
            8'h4C: make_code = 8'h4B;
            8'h4D: make_code = 8'h3A;
            8'h4E: make_code = 8'h31;
            8'h4F: make_code = 8'h44;
            8'h50: make_code = 8'h4D;
            8'h51: make_code = 8'h15;
            8'h52: make_code = 8'h2D;
            8'h53: make_code = 8'h1B;
            8'h54: make_code = 8'h2C;
            8'h55: make_code = 8'h3C;
            8'h56: make_code = 8'h2A;
            8'h57: make_code = 8'h1D;
            8'h58: make_code = 8'h22;
            8'h59: make_code = 8'h35;
            8'h5A: make_code = 8'h1A;
            8'h60: make_code = 8'h0E;
            8'h2D: make_code = 8'h4E;
            8'h3D: make_code = 8'h55;
            8'h5B: make_code = 8'h54;
            8'h5D: make_code = 8'h5B;
            8'h5C: make_code = 8'h5D;
            8'h3B: make_code = 8'h4C;
            8'h27: make_code = 8'h52;
            8'h2C: make_code = 8'h41;
            8'h2E: make_code = 8'h49;
            8'h2F: make_code = 8'h4A;
            8'h20: make_code = 8'h29;
            8'h0D: make_code = 8'h5A;
            8'h08: make_code = 8'h66;
            default: valid = 1'b0;
        endcase
    end
endmodule

// File: rtl/ascii2key_seq.sv
// Turns one accepted ASCII character into the PS/2 make/F0/make byte stream with an idle gap
// after each transmitted byte. ASCII2KEY_SHIFT_EN wraps uppercase letters in left-shift bytes.
module ascii2key_seq #(
    parameter int              GAP_W      = 16,
    parameter logic [GAP_W-1:0] GAP_CYCLES = 16'd1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ascii_code,
    input  logic       wr_ascii,
    output logic       ready,
    output logic [7:0] scan_code,
    output logic       wr_ps2,
    input  logic       tx_done_tick,
    output logic       done_tick,
    output logic       unmap_tick
);
    import ps2_kb_pkg::*;

    state_t           state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [7:0]       make_reg;
    logic [GAP_W-1:0] gap_reg;

    logic             lut_valid;
    logic [7:0]       lut_make;
    logic [7:0]       first_byte;
    logic [IDX_W-1:0] idx_next;
    logic [7:0]       byte_next;
    logic             last_byte;
    logic             step;

`ifdef ASCII2KEY_SHIFT_EN
    logic             lut_shift;
    logic             shift_reg;

    ascii2scan_lut u_lut (
        .ascii_code  (ascii_code),
        .valid       (lut_valid),
        .make_code   (lut_make),
        .needs_shift (lut_shift)
    );

    assign first_byte = lut_shift ? LSHIFT_CODE : lut_make;

    always_comb begin
        idx_next  = idx_reg + 1'b1;
        byte_next = make_reg;
        if (shift_reg) begin
            last_byte = (idx_reg == IDX_W'(SEQ_LEN_SHIFT - 1));
            case (idx_next)
                IDX_W'(1): byte_next = make_reg;
                IDX_W'(2): byte_next = BREAK_CODE;
                IDX_W'(3): byte_next = make_reg;
                IDX_W'(4): byte_next = BREAK_CODE;
                default:   byte_next = LSHIFT_CODE;
            endcase
        end else begin
            last_byte = (idx_reg == IDX_W'(SEQ_LEN_BASE - 1));
            byte_next = (idx_next == IDX_W'(1)) ? BREAK_CODE : make_reg;
        end
    end
`else
    ascii2scan_lut u_lut (
        .ascii_code (ascii_code),
        .valid      (lut_valid),
        .make_code  (lut_make)
    );

    assign first_byte = lut_make;

    always_comb begin
        idx_next  = idx_reg + 1'b1;
        last_byte = (idx_reg == IDX_W'(SEQ_LEN_BASE - 1));
        byte_next = (idx_next == IDX_W'(1)) ? BREAK_CODE : make_reg;
    end
`endif

    // A byte slot finishes either on tx_done (no gap) or when the gap counter expires.
    assign step = ((state_reg == WAIT_DONE) && tx_done_tick && (GAP_CYCLES == '0)) ||
                  ((state_reg == GAP) && (gap_reg == '0));

    assign ready = (state_reg == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            make_reg   <= 8'h00;
            gap_reg    <= '0;
            scan_code  <= 8'h00;
            wr_ps2     <= 1'b0;
            done_tick  <= 1'b0;
            unmap_tick <= 1'b0;
`ifdef ASCII2KEY_SHIFT_EN
            shift_reg  <= 1'b0;
`endif
        end else begin
            wr_ps2     <= 1'b0;
            done_tick  <= 1'b0;
            unmap_tick <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (wr_ascii) begin
                        if (lut_valid) begin
                            make_reg  <= lut_make;
                            idx_reg   <= '0;
                            scan_code <= first_byte;
                            wr_ps2    <= 1'b1;
                            state_reg <= SEND;
`ifdef ASCII2KEY_SHIFT_EN
                            shift_reg <= lut_shift;
`endif
                        end else begin
                            unmap_tick <= 1'b1;
                        end
                    end
                end
                SEND: state_reg <= WAIT_DONE;
                WAIT_DONE: begin
                    if (tx_done_tick && (GAP_CYCLES != '0)) begin
                        gap_reg   <= GAP_CYCLES - 1'b1;
                        state_reg <= GAP;
                    end
                end
                GAP: begin
                    if (gap_reg != '0)
                        gap_reg <= gap_reg - 1'b1;
                end
            endcase

            if (step) begin
                if (last_byte) begin
                    done_tick <= 1'b1;
                    state_reg <= IDLE;
                end else begin
                    idx_reg   <= idx_next;
                    scan_code <= byte_next;
                    wr_ps2    <= 1'b1;
                    state_reg <= SEND;
                end
            end
        end
    end
endmodule

// File: tb/tb_ascii2key_seq.sv
// Directed bench for ascii2key_seq: a PS/2 transmitter model answers each wr_ps2 with
// tx_done_tick 20 cycles later; one instance uses a 4-cycle gap, the other no gap.
`timescale 1ns/1ps
module tb_ascii2key_seq;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ascii_code, ascii0;
    logic       wr_ascii, wr0;
    logic       ready, wr_ps2, done_tick, unmap_tick, tx_done;
    logic [7:0] scan_code;
    logic       ready0, wr_ps20, done0, unmap0, tx_done0;
    logic [7:0] scan0;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int done_cnt = 0, unmap_cnt = 0, ready_err = 0, done0_cnt = 0;
    logic [7:0] byte_q[$];
    int         wr_cyc_q[$];
    int         txd_cyc_q[$];
    logic [7:0] byte0_q[$];
    int         wr0_cyc_q[$];
    int         txd0_cyc_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    ascii2key_seq #(.GAP_W(16), .GAP_CYCLES(16'd4)) dut (
        .clk(clk), .reset(rst), .ascii_code(ascii_code), .wr_ascii(wr_ascii),
        .ready(ready), .scan_code(scan_code), .wr_ps2(wr_ps2),
        .tx_done_tick(tx_done), .done_tick(done_tick), .unmap_tick(unmap_tick)
    );

    ascii2key_seq #(.GAP_W(16), .GAP_CYCLES(16'd0)) dut0 (
        .clk(clk), .reset(rst), .ascii_code(ascii0), .wr_ascii(wr0),
        .ready(ready0), .scan_code(scan0), .wr_ps2(wr_ps20),
        .tx_done_tick(tx_done0), .done_tick(done0), .unmap_tick(unmap0)
    );

    // PS/2 transmitter model and event recorder for both instances.
    initial begin
        int pend, pend0;
        pend = 0; pend0 = 0;
        tx_done = 1'b0; tx_done0 = 1'b0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (rst) begin
                pend = 0; pend0 = 0; tx_done = 1'b0; tx_done0 = 1'b0;
            end else begin
                tx_done = 1'b0;
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin tx_done = 1'b1; txd_cyc_q.push_back(cyc); end
                end
                if (wr_ps2) begin byte_q.push_back(scan_code); wr_cyc_q.push_back(cyc); pend = 20; end
                if (done_tick) done_cnt++;
                if (unmap_tick) unmap_cnt++;
                if ((wr_ps2 || pend > 0) && ready !== 1'b0) ready_err++;
                tx_done0 = 1'b0;
                if (pend0 > 0) begin
                    pend0--;
                    if (pend0 == 0) begin tx_done0 = 1'b1; txd0_cyc_q.push_back(cyc); end
                end
                if (wr_ps20) begin byte0_q.push_back(scan0); wr0_cyc_q.push_back(cyc); pend0 = 20; end
                if (done0) done0_cnt++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] c);
        @(negedge clk); ascii_code = c; wr_ascii = 1'b1;
        @(negedge clk); wr_ascii = 1'b0;
    endtask

    task automatic send0(input logic [7:0] c);
        @(negedge clk); ascii0 = c; wr0 = 1'b1;
        @(negedge clk); wr0 = 1'b0;
    endtask

    task automatic clear_log();
        byte_q.delete(); wr_cyc_q.delete(); txd_cyc_q.delete();
    endtask

    task automatic exp_base(input logic [7:0] m);
        exp_q.delete();
        exp_q.push_back(m); exp_q.push_back(8'hF0); exp_q.push_back(m);
    endtask

    task automatic exp_shift(input logic [7:0] m);
        exp_q.delete();
        exp_q.push_back(8'h12); exp_q.push_back(m); exp_q.push_back(8'hF0);
        exp_q.push_back(m); exp_q.push_back(8'hF0); exp_q.push_back(8'h12);
    endtask

    task automatic wait_done(input string tag, input int target, input bit inst0);
        int n;
        n = 0;
        while ((inst0 ? done0_cnt : done_cnt) < target && n < 400) begin
            @(negedge clk); n++;
        end
        check({tag, " done_seen"}, 32'((inst0 ? done0_cnt : done_cnt) >= target), 32'd1);
    endtask

    task automatic check_seq(input string tag, input logic [7:0] b[$], input int w[$],
                             input int t[$], input int gap);
        check({tag, " nbytes"}, b.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < b.size(); k++)
            check($sformatf("%s byte%0d", tag, k), b[k], exp_q[k]);
        for (int k = 1; k < w.size(); k++)
            check($sformatf("%s gap%0d", tag, k), (k - 1 < t.size()) ? w[k] - t[k - 1] : -1, gap);
    endtask

    initial begin
        int d, u, n;
        rst = 1'b1; wr_ascii = 1'b0; ascii_code = 8'h00; wr0 = 1'b0; ascii0 = 8'h00;
        repeat (3) @(negedge clk);
        check("rst ready", ready, 1);
        check("rst scan_code", scan_code, 8'h00);
        check("rst wr_ps2", wr_ps2, 0);
        check("rst done_tick", done_tick, 0);
        check("rst unmap_tick", unmap_tick, 0);
        check("rst ready0", ready0, 1);
        rst = 1'b0;
        @(negedge clk);

        // 'A'
        clear_log(); d = done_cnt;
        send(8'h41);
        check("A wr_ps2 latency", wr_ps2, 1);
        check("A ready low", ready, 0);
        wait_done("A", d + 1, 1'b0);
        repeat (40) @(negedge clk);
`ifdef ASCII2KEY_SHIFT_EN
        exp_shift(8'h1C);
`else
        exp_base(8'h1C);
`endif
        check_seq("A", byte_q, wr_cyc_q, txd_cyc_q, 5);
        check("A done once", done_cnt, d + 1);
        check("A ready back", ready, 1);

        // 'a' never shifted
        clear_log(); d = done_cnt;
        send(8'h61);
        wait_done("a", d + 1, 1'b0);
        repeat (40) @(negedge clk);
        exp_base(8'h1C);
        check_seq("a", byte_q, wr_cyc_q, txd_cyc_q, 5);

        // unmapped '~' then CR
        clear_log(); u = unmap_cnt;
        send(8'h7E);
        check("7E unmap_tick", unmap_tick, 1);
        check("7E no wr_ps2", wr_ps2, 0);
        check("7E ready", ready, 1);
        @(negedge clk);
        check("7E unmap one cycle", unmap_tick, 0);
        repeat (30) @(negedge clk);
        check("7E nothing sent", byte_q.size(), 0);
        check("7E unmap count", unmap_cnt, u + 1);
        d = done_cnt;
        send(8'h0D);
        wait_done("CR", d + 1, 1'b0);
        repeat (40) @(negedge clk);
        exp_base(8'h5A);
        check_seq("CR", byte_q, wr_cyc_q, txd_cyc_q, 5);

        // '1' then '2' while busy: the second is dropped
        clear_log(); d = done_cnt;
        send(8'h31);
        repeat (10) @(negedge clk);
        send(8'h32);
        wait_done("busy", d + 1, 1'b0);
        repeat (60) @(negedge clk);
        exp_base(8'h16);
        check_seq("busy", byte_q, wr_cyc_q, txd_cyc_q, 5);
        check("busy done once", done_cnt, d + 1);

        // reset while waiting on the second byte
        clear_log(); d = done_cnt;
        send(8'h31);
        n = 0;
        while (byte_q.size() < 2 && n < 200) begin @(negedge clk); n++; end
        check("rstmid reached byte2", 32'(byte_q.size() >= 2), 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstmid ready", ready, 1);
        check("rstmid wr_ps2", wr_ps2, 0);
        check("rstmid scan_code", scan_code, 8'h00);
        check("rstmid done_tick", done_tick, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        check("rstmid no more bytes", byte_q.size(), 2);
        check("rstmid no done", done_cnt, d);
        clear_log(); d = done_cnt;
        send(8'h20);
        wait_done("space", d + 1, 1'b0);
        repeat (40) @(negedge clk);
        exp_base(8'h29);
        check_seq("space", byte_q, wr_cyc_q, txd_cyc_q, 5);

        // zero-gap instance, backspace
        d = done0_cnt;
        send0(8'h08);
        check("BS wr_ps2 latency", wr_ps20, 1);
        wait_done("BS", d + 1, 1'b1);
        repeat (40) @(negedge clk);
        exp_base(8'h66);
        check_seq("BS", byte0_q, wr0_cyc_q, txd0_cyc_q, 1);

        check("ready low while busy", ready_err, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
